pmem_arbiter_n: RTL and testbench
=================================

// Module: pmem_arbiter_n
// PURPOSE
//  N-client arbiter between the L1 caches (icache, dcache, future victim/L2 ports) and the
//  single physical memory port. Selects one pending read or write, latches it, holds it on
//  pmem until pmem_resp, then routes the response back to the winner. Replaces the fixed
//  two-client arbiter; client count, widths and priority mode are parameters.
// PARAMETERS
//  NUM_CLIENTS  2    number of requesting caches, >= 2
//  ADDR_WIDTH   16   byte address width
//  BLOCK_WIDTH  128  cache line width (lc3b_c_block)
//  RR_MODE      1    1 = round-robin, 0 = fixed priority (lowest index wins)
//  IDXW = $clog2(NUM_CLIENTS), derived localparam
// PORTS
//  clk          in   1                       clock; all state updates on rising edge
//  rst_n        in   1                       synchronous reset, active low
//  cl_read      in   NUM_CLIENTS             per-client line read request, level, held until cl_resp
//  cl_write     in   NUM_CLIENTS             per-client line write request, level, held until cl_resp
//  cl_address   in   NUM_CLIENTS*ADDR_WIDTH  client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  cl_wdata     in   NUM_CLIENTS*BLOCK_WIDTH client i at [i*BLOCK_WIDTH +: BLOCK_WIDTH]
//  cl_resp      out  NUM_CLIENTS             one-cycle completion pulse to granted client only
//  cl_rdata     out  BLOCK_WIDTH             pmem_rdata passthrough, shared by all clients
//  pmem_read    out  1                       registered, high for the whole read transaction
//  pmem_write   out  1                       registered, high for the whole write transaction
//  pmem_address out  ADDR_WIDTH              latched address of the granted request
//  pmem_wdata   out  BLOCK_WIDTH             latched write data of the granted request
//  pmem_resp    in   1                       physical memory completion
//  pmem_rdata   in   BLOCK_WIDTH             physical memory read line
//  busy         out  1                       high while state == BUSY
//  grant_idx    out  IDXW                    index of current/last granted client
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state=IDLE; pmem_read=pmem_write=0; pmem_address=0;
//    pmem_wdata=0; grant_idx=0; rr pointer last=NUM_CLIENTS-1 (client 0 highest first).
//    cl_resp=0 and busy=0 while in IDLE. Reset mid-transaction aborts: next cycle is IDLE,
//    pmem strobes low; a late pmem_resp is ignored.
//  - pending[i] = cl_read[i] | cl_write[i].
//  - IDLE: if any pending, pick winner w; at the edge latch address/wdata of w,
//    grant_idx<=w, pmem_write<=cl_write[w], pmem_read<=cl_read[w] & ~cl_write[w]
//    (write wins if both asserted), state<=BUSY. No pending: stay IDLE.
//  - Winner, RR_MODE=1: first pending index scanning last+1, last+2, ... modulo
//    NUM_CLIENTS; last<=w on grant. RR_MODE=0: lowest pending index, last unused.
//  - BUSY: pmem outputs held constant; client inputs ignored (changes do not affect pmem).
//    When pmem_resp=1: cl_resp[grant_idx]=1 combinationally in that cycle, all other
//    cl_resp bits 0; at the edge pmem_read/write<=0, state<=IDLE.
//  - Latency: request visible in IDLE at cycle 0 -> pmem strobe high in cycle 1.
//    pmem_resp in cycle k -> cl_resp same cycle k; earliest next grant edge ends cycle k+1.
//  - Client drops its request the edge after cl_resp; IDLE therefore never re-grants a
//    completed request. Back-to-back requests from different clients: one idle cycle
//    between transactions.
//  - pmem_resp while IDLE is ignored; cl_rdata is always pmem_rdata (valid only with cl_resp).
//  - No starvation in RR mode: a pending client is granted within NUM_CLIENTS transactions.
// TESTING
//  1. rst_n=0 one edge with all requests high -> IDLE, pmem_read=pmem_write=0, busy=0, cl_resp=0.
//  2. N=2: cl_read=2'b01, addr0=16'h1230; pmem_resp after 5 cycles -> pmem_read cycle 1..5,
//     pmem_address=16'h1230, cl_resp=2'b01 in cycle 5 only, cl_rdata=pmem_rdata.
//  3. RR, N=4, all four cl_read held high, each resp 3 cycles -> grant order 0,1,2,3,0.
//  4. RR_MODE=0, N=4, clients 1 and 3 always pending -> client 1 granted every time.
//  5. cl_read[1]=cl_write[1]=1, wdata=128'hA5..A5 -> pmem_write=1, pmem_read=0, wdata latched;
//     changing cl_address[1] during BUSY leaves pmem_address unchanged.
//  6. rst_n=0 during BUSY, then pmem_resp=1 in IDLE -> strobes 0 next cycle, no cl_resp pulse.

Source files
------------

// File: rtl/pmem_arbiter_n.sv
// N-client arbiter in front of the single physical memory port: grants one pending line read/write,
// holds it on pmem until pmem_resp, then pulses cl_resp to the winner. Round-robin or fixed priority.
module pmem_arbiter_n #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WIDTH = 128,
  parameter int RR_MODE     = 1,
  localparam int IDXW       = $clog2(NUM_CLIENTS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CLIENTS-1:0]             cl_read,
  input  logic [NUM_CLIENTS-1:0]             cl_write,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]  cl_address,
  input  logic [NUM_CLIENTS*BLOCK_WIDTH-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]             cl_resp,
  output logic [BLOCK_WIDTH-1:0]             cl_rdata,
  output logic                               pmem_read,
  output logic                               pmem_write,
  output logic [ADDR_WIDTH-1:0]              pmem_address,
  output logic [BLOCK_WIDTH-1:0]             pmem_wdata,
  input  logic                               pmem_resp,
  input  logic [BLOCK_WIDTH-1:0]             pmem_rdata,
  output logic                               busy,
  output logic [IDXW-1:0]                    grant_idx
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]             r_state;
  logic [IDXW-1:0]        r_grant;
  logic [IDXW-1:0]        r_last;
  logic                   r_pread;
  logic                   r_pwrite;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [BLOCK_WIDTH-1:0] r_wdata;

  logic [NUM_CLIENTS-1:0] w_pending;
  logic                   w_found;
  logic [IDXW-1:0]        w_win;
  logic [IDXW-1:0]        w_idx;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [BLOCK_WIDTH-1:0] w_wdata;

  // Scan starts just past the last winner in RR mode, at client 0 otherwise.
  always_comb begin
    w_pending = cl_read | cl_write;
    w_found   = 1'b0;
    w_win     = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (RR_MODE != 0) w_idx = IDXW'((int'(r_last) + 1 + k) % NUM_CLIENTS);
      else              w_idx = IDXW'(k);
      if (!w_found && w_pending[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (w_win == IDXW'(i)) begin
        w_addr  = cl_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = cl_wdata[i*BLOCK_WIDTH +: BLOCK_WIDTH];
      end
    end
  end

  always_comb begin
    cl_resp = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cl_resp[i] = (r_state == S_BUSY) && pmem_resp && (r_grant == IDXW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_last   <= IDXW'(NUM_CLIENTS - 1);
      r_pread  <= 1'b0;
      r_pwrite <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state  <= S_BUSY;
            r_grant  <= w_win;
            if (RR_MODE != 0) r_last <= w_win;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            // a client asserting both strobes is served as a write
            r_pwrite <= cl_write[w_win];
            r_pread  <= cl_read[w_win] & ~cl_write[w_win];
          end
        end
        S_BUSY: begin
          if (pmem_resp) begin
            r_state  <= S_IDLE;
            r_pread  <= 1'b0;
            r_pwrite <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cl_rdata     = pmem_rdata;
  assign pmem_read    = r_pread;
  assign pmem_write   = r_pwrite;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign busy         = (r_state == S_BUSY);
  assign grant_idx    = r_grant;

endmodule

// File: tb/tb_pmem_arbiter_n.sv
// Bench for pmem_arbiter_n: a round-robin and a fixed-priority 4-client instance, each with a
// latency-programmable memory responder and a scoreboard queue checked on every cl_resp pulse.
module tb_pmem_arbiter_n;

  typedef struct {
    int           idx;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic         wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // round-robin instance
  logic [3:0]   rr_read, rr_write, rr_resp;
  logic [63:0]  rr_addr;
  logic [511:0] rr_wdata;
  logic [127:0] rr_rdata, rr_pwdata, rr_prdata;
  logic         rr_pr, rr_pw, rr_presp, rr_busy;
  logic [15:0]  rr_paddr;
  logic [1:0]   rr_gidx;
  logic         rr_resp_m = 1'b0, rr_force = 1'b0;
  int           rr_lat = 3, rr_cnt = 0, rr_done = 0;
  exp_t         rr_q[$];
  exp_t         rr_e;

  // fixed-priority instance
  logic [3:0]   f_read, f_write, f_resp;
  logic [63:0]  f_addr;
  logic [511:0] f_wdata;
  logic [127:0] f_rdata, f_pwdata, f_prdata;
  logic         f_pr, f_pw, f_presp, f_busy;
  logic [15:0]  f_paddr;
  logic [1:0]   f_gidx;
  logic         f_resp_m = 1'b0;
  int           f_lat = 3, f_cnt = 0, f_done = 0;
  exp_t         f_q[$];
  exp_t         f_e;

  function automatic logic [127:0] rdata_of(input logic [15:0] a);
    return {8{a ^ 16'h5A5A}};
  endfunction

  pmem_arbiter_n #(.NUM_CLIENTS(4), .ADDR_WIDTH(16), .BLOCK_WIDTH(128), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .cl_read(rr_read), .cl_write(rr_write), .cl_address(rr_addr),
    .cl_wdata(rr_wdata), .cl_resp(rr_resp), .cl_rdata(rr_rdata), .pmem_read(rr_pr),
    .pmem_write(rr_pw), .pmem_address(rr_paddr), .pmem_wdata(rr_pwdata), .pmem_resp(rr_presp),
    .pmem_rdata(rr_prdata), .busy(rr_busy), .grant_idx(rr_gidx));

  pmem_arbiter_n #(.NUM_CLIENTS(4), .ADDR_WIDTH(16), .BLOCK_WIDTH(128), .RR_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .cl_read(f_read), .cl_write(f_write), .cl_address(f_addr),
    .cl_wdata(f_wdata), .cl_resp(f_resp), .cl_rdata(f_rdata), .pmem_read(f_pr),
    .pmem_write(f_pw), .pmem_address(f_paddr), .pmem_wdata(f_pwdata), .pmem_resp(f_presp),
    .pmem_rdata(f_prdata), .busy(f_busy), .grant_idx(f_gidx));

  assign rr_prdata = rdata_of(rr_paddr);
  assign f_prdata  = rdata_of(f_paddr);
  assign rr_presp  = rr_resp_m | rr_force;
  assign f_presp   = f_resp_m;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // memory model: respond after the strobe has been high for *_lat cycles
  always @(posedge clk) begin
    #1;
    if (rr_pr | rr_pw) begin rr_cnt++; rr_resp_m = (rr_cnt == rr_lat); end
    else begin rr_cnt = 0; rr_resp_m = 1'b0; end
    if (f_pr | f_pw) begin f_cnt++; f_resp_m = (f_cnt == f_lat); end
    else begin f_cnt = 0; f_resp_m = 1'b0; end
  end

  always @(negedge clk) begin
    if (mon_en && rr_resp != 4'b0000) begin
      if (rr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rr_unexpected_resp actual=%b required=0000", rr_resp);
      end else begin
        rr_e = rr_q.pop_front();
        chk("rr_resp_onehot", rr_resp, 4'b0001 << rr_e.idx);
        chk("rr_grant_idx", rr_gidx, rr_e.idx);
        chk("rr_pmem_address", rr_paddr, rr_e.addr);
        chk("rr_pmem_write", rr_pw, rr_e.wr);
        chk("rr_pmem_read", rr_pr, !rr_e.wr);
        if (rr_e.wr) chk("rr_pmem_wdata", rr_pwdata, rr_e.wdata);
        chk("rr_cl_rdata", rr_rdata, rdata_of(rr_e.addr));
        rr_done++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && f_resp != 4'b0000) begin
      if (f_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL fp_unexpected_resp actual=%b required=0000", f_resp);
      end else begin
        f_e = f_q.pop_front();
        chk("fp_resp_onehot", f_resp, 4'b0001 << f_e.idx);
        chk("fp_grant_idx", f_gidx, f_e.idx);
        chk("fp_pmem_address", f_paddr, f_e.addr);
        chk("fp_cl_rdata", f_rdata, rdata_of(f_e.addr));
        f_done++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // advance until the selected monitor has seen 'target' responses; returns cycles taken
  task automatic wait_cnt(input bit fp, input int target, output int cyc);
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      cyc++;
      if ((fp ? f_done : rr_done) >= target) return;
    end
    checks++; errors++;
    $display("FAIL wait_timeout actual=%0d required=%0d", fp ? f_done : rr_done, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cyc, base;
    int ord[5];
    ord = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    rr_read = 4'hF; rr_write = 4'hF; rr_addr = {4{16'hFFFF}}; rr_wdata = '1;
    f_read  = 4'hF; f_write  = 4'hF; f_addr  = {4{16'hFFFF}}; f_wdata  = '1;

    // reset with every request asserted
    tick();
    chk("t1_pmem_read", rr_pr, 1'b0);
    chk("t1_pmem_write", rr_pw, 1'b0);
    chk("t1_busy", rr_busy, 1'b0);
    chk("t1_cl_resp", rr_resp, 4'b0000);
    chk("t1_grant_idx", rr_gidx, 2'd0);
    chk("t1_pmem_address", rr_paddr, 16'h0000);
    chk("t1_fp_strobes", {f_pr, f_pw, f_busy}, 3'b000);
    rr_read = '0; rr_write = '0; f_read = '0; f_write = '0;
    rr_addr = '0; rr_wdata = '0; f_addr = '0; f_wdata = '0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // single read, memory answers in the fifth strobe cycle
    rr_lat = 5;
    rr_q.push_back('{idx: 0, addr: 16'h1230, wdata: '0, wr: 1'b0});
    rr_addr[15:0] = 16'h1230;
    rr_read = 4'b0001;
    @(negedge clk);
    chk("t2_idle_cycle0", {rr_pr, rr_busy}, 2'b00);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("t2_pmem_read", rr_pr, 1'b1);
      chk("t2_pmem_address", rr_paddr, 16'h1230);
      chk("t2_cl_resp", rr_resp, (c == 5) ? 4'b0001 : 4'b0000);
    end
    tick();
    rr_read = 4'b0000;
    @(negedge clk);
    chk("t2_after_resp", {rr_pr, rr_busy}, 2'b00);

    // round-robin with all four clients reading continuously
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rr_lat = 3;
    base = rr_done;
    for (int i = 0; i < 4; i++) rr_addr[i*16 +: 16] = 16'h4000 + 16'(i * 16);
    for (int i = 0; i < 5; i++)
      rr_q.push_back('{idx: ord[i], addr: 16'h4000 + 16'(ord[i] * 16), wdata: '0, wr: 1'b0});
    rr_read = 4'hF;
    wait_cnt(1'b0, base + 5, cyc);
    rr_read = 4'h0;
    chk("t3_cycles_with_idle_gaps", cyc, 20);

    // fixed priority, clients 1 and 3 permanently pending
    f_lat = 3;
    f_addr[16 +: 16] = 16'h1111;
    f_addr[48 +: 16] = 16'h3333;
    for (int i = 0; i < 3; i++) f_q.push_back('{idx: 1, addr: 16'h1111, wdata: '0, wr: 1'b0});
    f_read = 4'b1010;
    wait_cnt(1'b1, 3, cyc);
    f_read = 4'b0000;
    chk("t4_cycles", cyc, 12);

    // read+write from client 1 is a write; address changes while busy are ignored
    rr_lat = 4;
    base = rr_done;
    rr_q.push_back('{idx: 1, addr: 16'hBEEF, wdata: {16{8'hA5}}, wr: 1'b1});
    rr_addr[16 +: 16] = 16'hBEEF;
    rr_wdata[128 +: 128] = {16{8'hA5}};
    rr_read = 4'b0010;
    rr_write = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    chk("t5_pmem_write", rr_pw, 1'b1);
    chk("t5_pmem_read", rr_pr, 1'b0);
    chk("t5_pmem_wdata", rr_pwdata, {16{8'hA5}});
    chk("t5_grant_idx", rr_gidx, 2'd1);
    rr_addr[16 +: 16] = 16'h0000;
    rr_wdata[128 +: 128] = '0;
    @(negedge clk);
    chk("t5_addr_held", rr_paddr, 16'hBEEF);
    chk("t5_wdata_held", rr_pwdata, {16{8'hA5}});
    wait_cnt(1'b0, base + 1, cyc);
    rr_read = 4'b0000;
    rr_write = 4'b0000;

    // reset mid-transaction, then a stray pmem_resp while idle
    rr_lat = 10;
    rr_addr[32 +: 16] = 16'h2222;
    rr_read = 4'b0100;
    tick();
    tick();
    chk("t6_busy_before_reset", {rr_busy, rr_pr}, 2'b11);
    rst_n = 1'b0;
    rr_read = 4'b0000;
    tick();
    rst_n = 1'b1;
    rr_force = 1'b1;
    @(negedge clk);
    chk("t6_strobes_after_reset", {rr_pr, rr_pw, rr_busy}, 3'b000);
    chk("t6_no_cl_resp", rr_resp, 4'b0000);
    tick();
    rr_force = 1'b0;
    @(negedge clk);
    chk("t6_stays_idle", {rr_pr, rr_busy}, 2'b00);

    chk("rr_queue_drained", rr_q.size(), 0);
    chk("fp_queue_drained", f_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
